// File: rtl/plab3_mem_cacheline_responder_pkg.sv
// Shared types and helpers for the cacheline memory responder.
package plab3_mem_cacheline_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    localparam logic [2:0] mem_type_write      = 3'd1;
    localparam logic [2:0] mem_type_write_init = 3'd2;

    // Write-init is a plain write here; every unknown type falls back to read.
    function automatic logic is_write_type(input logic [2:0] t);
        return (t == mem_type_write) || (t == mem_type_write_init);
    endfunction

endpackage

// File: rtl/plab3_mem_line_byte_align.sv
// Byte-lane alignment between a request (offset/len) and a 16-byte storage line.
module plab3_mem_line_byte_align (
    input  logic [3:0]   off,
    input  logic [3:0]   len,
    input  logic [127:0] wdata,
    input  logic [127:0] line,
    output logic [15:0]  wben,
    output logic [127:0] wdata_aligned,
    output logic [127:0] rdata
);

    logic [15:0]  nmask;
    logic [6:0]   shamt;
    logic [127:0] line_shifted;

    // len==0 encodes a full 16-byte access
    assign nmask         = (len == 4'd0) ? 16'hffff : ((16'd1 << len) - 16'd1);
    assign shamt         = {off, 3'b000};
    assign wben          = nmask << off;
    assign wdata_aligned = wdata << shamt;
    assign line_shifted  = line >> shamt;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 16; i++) begin
            if (nmask[i]) begin
                rdata[8*i +: 8] = line_shifted[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/plab3_mem_cacheline_responder.sv
// Main-memory responder: services cacheline read/write requests from internal storage
// after a fixed latency, one outstanding request at a time.
module plab3_mem_cacheline_responder
    import plab3_mem_cacheline_responder_pkg::*;
#(
    parameter int unsigned nlines  = 256,
    parameter int unsigned latency = 2,
    parameter int unsigned abw     = 32,
    parameter int unsigned clw     = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [clw+abw+14:0] memreq_msg,
    input  logic               memreq_val,
    output logic               memreq_rdy,
    output logic [clw+14:0]    memresp_msg,
    output logic               memresp_val,
    input  logic               memresp_rdy,
    output logic [31:0]        num_reqs
);

    localparam int unsigned idw      = $clog2(nlines);
    localparam int unsigned len_lsb  = clw;
    localparam int unsigned addr_lsb = clw + 4;
    localparam int unsigned opq_lsb  = clw + abw + 4;
    localparam int unsigned type_lsb = clw + abw + 12;
    localparam logic [3:0]  lat      = 4'(latency);

    logic [2:0]     req_type;
    logic [7:0]     req_opaque;
    logic [3:0]     req_len;
    logic [3:0]     req_off;
    logic [idw-1:0] req_idx;
    logic [clw-1:0] req_data;
    logic           req_is_write;

    assign req_type     = memreq_msg[type_lsb +: 3];
    assign req_opaque   = memreq_msg[opq_lsb +: 8];
    assign req_len      = memreq_msg[len_lsb +: 4];
    assign req_off      = memreq_msg[addr_lsb +: 4];
    assign req_idx      = memreq_msg[addr_lsb + 4 +: idw];
    assign req_data     = memreq_msg[0 +: clw];
    assign req_is_write = is_write_type(req_type);

    // Address bits above the line index alias onto the same storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^memreq_msg[addr_lsb + abw - 1 : addr_lsb + 4 + idw];

    logic [clw-1:0] mem [nlines];
    logic [clw-1:0] line_rd;
    logic [15:0]    wben;
    logic [clw-1:0] wdata_aligned;
    logic [clw-1:0] rdata;

    assign line_rd = mem[req_idx];

    plab3_mem_line_byte_align u_align (
        .off           (req_off),
        .len           (req_len),
        .wdata         (req_data),
        .line          (line_rd),
        .wben          (wben),
        .wdata_aligned (wdata_aligned),
        .rdata         (rdata)
    );

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [clw+14:0] resp_q, resp_d;
    logic [31:0]    num_reqs_q, num_reqs_d;
    logic           fire;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        num_reqs_d  = num_reqs_q;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        fire        = 1'b0;
        unique case (state_q)
            StIdle: begin
                memreq_rdy = ~reset;
                fire       = memreq_val & ~reset;
                if (fire) begin
                    cnt_d      = lat;
                    state_d    = (lat != 4'd0) ? StWait : StResp;
                    resp_d     = {req_type, req_opaque, req_len, req_is_write ? '0 : rdata};
                    num_reqs_d = num_reqs_q + 32'd1;
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            resp_q     <= '0;
            num_reqs_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            num_reqs_q <= num_reqs_d;
        end
    end

    // Storage is deliberately not reset; writes commit at the end of the fire cycle.
    always_ff @(posedge clk) begin
        if (fire && req_is_write) begin
            for (int i = 0; i < 16; i++) begin
                if (wben[i]) begin
                    mem[req_idx][8*i +: 8] <= wdata_aligned[8*i +: 8];
                end
            end
        end
    end

    assign memresp_msg = resp_q;
    assign num_reqs    = num_reqs_q;

endmodule

// File: tb/tb_plab3_mem_cacheline_responder.sv
// Scoreboard bench for the cacheline responder against a byte-array memory model.
module tb_plab3_mem_cacheline_responder;

    localparam int unsigned LAT = 3;
    localparam int unsigned NL  = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [174:0] memreq_msg = '0;
    logic         memreq_val = 1'b0;
    logic         memreq_rdy;
    logic [142:0] memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy = 1'b0;
    logic [31:0]  num_reqs;

    plab3_mem_cacheline_responder #(
        .nlines  (NL),
        .latency (LAT),
        .abw     (32),
        .clw     (128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .num_reqs    (num_reqs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [142:0] msg;
        int           cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mdl [NL][16];
    int unsigned mdl_count = 0;
    int          stall_req = 0;

    task automatic chk(input string nm, input logic [142:0] act, input logic [142:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Memory as 16-byte arrays; returns the response data for this request.
    function automatic logic [127:0] model_access(input logic [2:0] typ, input logic [31:0] addr,
                                                  input logic [3:0] len, input logic [127:0] data);
        int          idx = int'((addr / 16) % NL);
        int          off = int'(addr % 16);
        int          n = (len == 0) ? 16 : int'(len);
        bit          wr = (typ == 3'd1) || (typ == 3'd2);
        logic [127:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 16) begin
                if (wr) mdl[idx][off + i] = data[8*i +: 8];
                else    r[8*i +: 8] = mdl[idx][off + i];
            end
        end
        return wr ? 128'd0 : r;
    endfunction

    task automatic send(input logic [2:0] typ, input logic [7:0] op, input logic [31:0] addr,
                        input logic [3:0] len, input logic [127:0] data, input bit use_exp,
                        input logic [127:0] exp_data, output int fire_cyc);
        logic [127:0] d;
        int w = 0;
        @(negedge clk);
        memreq_msg = {typ, op, addr, len, data};
        memreq_val = 1'b1;
        while (!memreq_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!memreq_rdy) begin
            checks++;
            failures++;
            $display("FAIL req_rdy_timeout: got rdy=0 expected rdy=1 within 200 cycles");
            memreq_val = 1'b0;
            fire_cyc = -1;
            return;
        end
        fire_cyc = cyc;
        d = model_access(typ, addr, len, data);
        if (use_exp) d = exp_data;
        sbq.push_back('{msg: {typ, op, len, d}, cyc: cyc + 1 + int'(LAT)});
        mdl_count++;
        @(negedge clk);
        memreq_val = 1'b0;
        chk("num_reqs", {111'd0, num_reqs}, {111'd0, mdl_count});
    endtask

    // Monitor: pops the scoreboard on each new response and drives memresp_rdy.
    bit           in_resp = 0;
    bit           just_done = 0;
    int           stall_left = 0;
    logic [142:0] held;
    exp_t         e;
    always @(negedge clk) begin
        if (reset) begin
            in_resp = 0;
            just_done = 0;
            memresp_rdy = 1'b0;
        end else begin
            if (just_done) chk_int("resp_val_after_accept", int'(memresp_val), 0);
            just_done = 0;
            if (memresp_val) begin
                chk_int("req_rdy_in_resp", int'(memreq_rdy), 0);
                if (!in_resp) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp: got msg %h expected no response",
                                 memresp_msg);
                        held = memresp_msg;
                    end else begin
                        e = sbq.pop_front();
                        chk("resp_msg", memresp_msg, e.msg);
                        chk_int("resp_cycle", cyc, e.cyc);
                        held = e.msg;
                    end
                    in_resp = 1;
                    stall_left = (stall_req > 0) ? stall_req : int'($urandom_range(0, 2));
                    stall_req = 0;
                end else begin
                    chk("resp_stable", memresp_msg, held);
                end
                if (stall_left > 0) begin
                    memresp_rdy = 1'b0;
                    stall_left--;
                end else begin
                    memresp_rdy = 1'b1;
                    in_resp = 0;
                    just_done = 1;
                end
            end else begin
                memresp_rdy = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int fc;
        int w;
        logic [127:0] d1;
        logic [127:0] d6;
        d1 = 128'h0123456789abcdef0123456789abcdef;
        d6 = 128'hfeedface_00c0ffee_12345678_9abcdef0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_int("reset_resp_val", int'(memresp_val), 0);
        chk("reset_resp_msg", memresp_msg, '0);
        chk_int("reset_num_reqs", int'(num_reqs), 0);
        reset = 1'b0;
        #1;
        chk_int("reset_req_rdy", int'(memreq_rdy), 1);

        // Preload every line so later reads are fully defined
        for (int i = 0; i < int'(NL); i++) begin
            send(3'd1, 8'(i), 32'(i * 16), 4'd0, {$urandom, $urandom, $urandom, $urandom},
                 0, '0, fc);
        end

        // Full-line write then read back
        send(3'd1, 8'h11, 32'h100, 4'd0, d1, 1, 128'd0, fc);
        send(3'd0, 8'h12, 32'h100, 4'd0, '0, 1, d1, fc);

        // Request ready stays low through WAIT and the first RESP cycle
        send(3'd0, 8'h22, 32'h100, 4'd0, '0, 0, '0, fc);
        for (int k = 0; k <= int'(LAT); k++) begin
            chk_int("req_rdy_wait", int'(memreq_rdy), 0);
            @(negedge clk);
        end

        // Partial access clipped at the line end
        send(3'd1, 8'h30, 32'h200, 4'd0, {16{8'haa}}, 0, '0, fc);
        send(3'd2, 8'h31, 32'h20e, 4'd4, 128'h44332211, 0, '0, fc);
        send(3'd0, 8'h32, 32'h20c, 4'd4, '0, 1, 128'h2211aaaa, fc);
        send(3'd5, 8'h33, 32'h200, 4'd0, '0, 1, 128'h2211_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa, fc);

        // Backpressure for 5 cycles
        stall_req = 5;
        send(3'd0, 8'h40, 32'h200, 4'd0, '0, 0, '0, fc);

        // Reset in WAIT after a committed write
        send(3'd1, 8'h66, 32'h300, 4'd0, d6, 0, '0, fc);
        #2;
        reset = 1'b1;
        #1;
        chk_int("async_reset_resp_val", int'(memresp_val), 0);
        chk_int("async_reset_num_reqs", int'(num_reqs), 0);
        sbq.delete();
        mdl_count = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_int("post_reset_req_rdy", int'(memreq_rdy), 1);
        repeat (LAT + 4) @(negedge clk);

        // Address wrap modulo nlines*16
        send(3'd1, 8'h50, 32'h1000, 4'd0, ~d1, 0, '0, fc);
        send(3'd0, 8'h51, 32'h0, 4'd0, '0, 1, ~d1, fc);
        send(3'd0, 8'h67, 32'h300, 4'd0, '0, 1, d6, fc);

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), $urandom, 4'($urandom_range(0, 15)),
                 {$urandom, $urandom, $urandom, $urandom}, 0, '0, fc);
        end

        w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk_int("drain_pending", sbq.size(), 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
